// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and defaults for the serial pattern generator: FSM state
// encoding, default field widths and the pattern-length clamp.
package seq_gen_pkg;

  localparam int PW = 8;
  localparam int LW = 4;
  localparam int RW = 4;
  localparam int GW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  // A length of zero, or one wider than the pattern register, means "all bits".
  function automatic int eff_len(input int len, input int pw);
    return (len == 0 || len > pw) ? pw : len;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle between a controller (master) and the pattern
// generator (slave).
interface seq_pattern_gen_if #(
  parameter int PW = seq_gen_pkg::PW,
  parameter int LW = seq_gen_pkg::LW,
  parameter int RW = seq_gen_pkg::RW,
  parameter int GW = seq_gen_pkg::GW
);

  logic          start;
  logic          abort;
  logic [PW-1:0] pattern;
  logic [LW-1:0] len;
  logic [RW-1:0] rep;
  logic [GW-1:0] gap;
  logic          ready;
  logic          dout;
  logic          dvalid;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, pattern, len, rep, gap,
    input  ready, dout, dvalid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, rep, gap,
    output ready, dout, dvalid, busy, done
  );

endinterface

// File: rtl/seq_pattern_gen_serializer.sv
// MSB-first parallel-load shift register. The loaded field is left-aligned and
// padded with the idle level, so the output falls to idle once it is used up.
module bit_serializer #(
  parameter int   PW       = seq_gen_pkg::PW,
  parameter int   LW       = seq_gen_pkg::LW,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic          shift,
  input  logic [PW-1:0] data,
  input  logic [LW-1:0] len,
  output logic          dout
);

  localparam logic [PW-1:0] FILL = {PW{IDLE_LVL}};

  logic [PW-1:0] sr;
  logic [PW-1:0] aligned;

  // data[len-1:0] moves to the top; the bits below it read as the idle level.
  assign aligned = (data << (PW - int'(len))) | (FILL >> len);

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register here (shadow storage included) has a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= FILL;
    end else if (clear) begin
      sr <= FILL;
    end else if (load) begin
      sr <= aligned;
    end else if (shift) begin
      sr <= {sr[PW-2:0], IDLE_LVL};
    end
  end

  assign dout = sr[PW-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first for a number of
// passes with optional idle gaps, then pulses done. All outputs are registered.
module seq_pattern_gen #(
  parameter int   PW       = seq_gen_pkg::PW,
  parameter int   LW       = seq_gen_pkg::LW,
  parameter int   RW       = seq_gen_pkg::RW,
  parameter int   GW       = seq_gen_pkg::GW,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_pattern_gen_if.slave    bus
);

  import seq_gen_pkg::*;

  state_t        state, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d, len_in;
  logic [LW-1:0] bit_cnt, bit_d;
  logic [RW-1:0] pass_cnt, pass_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          ld, sh, clr;
  logic [PW-1:0] ld_pat;
  logic [LW-1:0] ld_len;
  logic          ready_q, busy_q, dvalid_q, done_q;

  assign len_in = LW'(eff_len(int'(bus.len), PW));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    pat_d     = pat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    bit_d     = bit_cnt;
    pass_d    = pass_cnt;
    gap_cnt_d = gap_cnt;
    ld        = 1'b0;
    sh        = 1'b0;
    clr       = 1'b0;
    ld_pat    = pat_q;
    ld_len    = len_q;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          pat_d   = bus.pattern;
          len_d   = len_in;
          gap_d   = bus.gap;
          pass_d  = (bus.rep == '0) ? '0 : bus.rep - 1'b1;
          bit_d   = len_in - 1'b1;
          ld      = 1'b1;
          ld_pat  = bus.pattern;
          ld_len  = len_in;
        end
      end
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          bit_d = bit_cnt - 1'b1;
          sh    = 1'b1;
        end else if (pass_cnt != '0) begin
          pass_d = pass_cnt - 1'b1;
          if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q - 1'b1;
            sh        = 1'b1;
          end else begin
            // Back-to-back pass: reload now so the next MSB follows with no bubble.
            ld    = 1'b1;
            bit_d = len_q - 1'b1;
          end
        end else begin
          state_d = S_DONE;
          sh      = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_d = gap_cnt - 1'b1;
        end else begin
          state_d = S_SHIFT;
          ld      = 1'b1;
          bit_d   = len_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats every internal transition but never cancels an IDLE start.
    if (bus.abort && state != S_IDLE) begin
      state_d = S_IDLE;
      clr     = 1'b1;
      ld      = 1'b0;
      sh      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      bit_cnt  <= '0;
      pass_cnt <= '0;
      gap_cnt  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      bit_cnt  <= bit_d;
      pass_cnt <= pass_d;
      gap_cnt  <= gap_cnt_d;
      ready_q  <= (state_d == S_IDLE);
      busy_q   <= (state_d == S_SHIFT) || (state_d == S_GAP);
      dvalid_q <= (state_d == S_SHIFT);
      done_q   <= (state_d == S_DONE);
    end
  end

  bit_serializer #(
    .PW       (PW),
    .LW       (LW),
    .IDLE_LVL (IDLE_LVL)
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr),
    .load  (ld),
    .shift (sh),
    .data  (ld_pat),
    .len   (ld_len),
    .dout  (bus.dout)
  );

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.dvalid = dvalid_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: each request queues its hand-written
// per-cycle output trace, and a monitor pops and compares one entry per cycle.
module tb_seq_pattern_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.PW(8), .LW(4), .RW(4), .GW(4)) ifc ();

  seq_pattern_gen #(
    .PW(8), .LW(4), .RW(4), .GW(4), .IDLE_LVL(1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // Observed outputs packed as {ready, busy, dvalid, dout, done}.
  wire [4:0] obs = {ifc.ready, ifc.busy, ifc.dvalid, ifc.dout, ifc.done};

  int         total = 0;
  int         bad   = 0;
  logic [4:0] exp_q[$];
  int         exp_total = 0;
  string      cur_test  = "reset";
  logic [4:0] mon_e;
  int         mon_idx;

  bit         lb_on = 1'b0;
  logic [2:0] hist;
  int         lb_cnt;
  int         y_pos[$];
  int         y_exp[5] = '{4, 6, 8, 10, 12};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Trace alphabet: '0'/'1' data bit, 'g' gap cycle, 'D' done pulse, 'r' idle+ready.
  function automatic void push_stream(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "0":     exp_q.push_back(5'b01100);
        "1":     exp_q.push_back(5'b01110);
        "g":     exp_q.push_back(5'b01000);
        "D":     exp_q.push_back(5'b00001);
        default: exp_q.push_back(5'b10000);
      endcase
    end
  endfunction

  // Start pulse lands on edge k; the trace begins in cycle k+1. Inputs are
  // scrambled afterwards to show the shadow registers hold the request.
  task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                    input logic [3:0] g, input string name, input string s);
    @(negedge clk);
    ifc.pattern = p;
    ifc.len     = l;
    ifc.rep     = r;
    ifc.gap     = g;
    ifc.start   = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    cur_test  = name;
    exp_total = s.len();
    push_stream(s);
    ifc.pattern = 8'($urandom);
    ifc.len     = 4'($urandom);
    ifc.rep     = 4'($urandom);
    ifc.gap     = 4'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain %s: %0d entries left, expected 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() != 0) begin
      mon_idx = exp_total - exp_q.size();
      mon_e   = exp_q.pop_front();
      check($sformatf("%s[%0d]", cur_test, mon_idx), 32'(obs), 32'(mon_e));
    end
  end

  // Reference "0101" overlapping Mealy detector fed from the valid stream.
  always @(negedge clk) begin
    if (!lb_on) begin
      hist   = 3'b111;
      lb_cnt = 0;
    end else if (ifc.dvalid) begin
      lb_cnt++;
      if ({hist, ifc.dout} == 4'b0101) y_pos.push_back(lb_cnt);
      hist = {hist[1:0], ifc.dout};
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.start   = 1'b0;
    ifc.abort   = 1'b0;
    ifc.pattern = '0;
    ifc.len     = '0;
    ifc.rep     = '0;
    ifc.gap     = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs), 32'h10);
    rst_n = 1'b1;
    @(negedge clk);

    go(8'b0000_0101, 4'd4, 4'd1, 4'd0, "single", "0101Dr");
    drain();

    go(8'b0000_0101, 4'd3, 4'd2, 4'd2, "repeat_gap", "101gg101Dr");
    drain();

    go(8'hA5, 4'd0, 4'd0, 4'd0, "clamp", "10100101Dr");
    drain();

    // Start mid-transfer and in the DONE cycle must both be ignored.
    go(8'b0000_0010, 4'd2, 4'd3, 4'd0, "b2b_ignore", "101010Drr");
    @(posedge clk);
    #1 ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    drain();

    // Abort held with start in IDLE: start wins. Abort again during bit 3.
    ifc.abort = 1'b1;
    go(8'hC3, 4'd8, 4'd1, 4'd0, "abort", "110rr");
    repeat (2) @(posedge clk);
    #1 ifc.abort = 1'b1;
    @(posedge clk);
    #1 ifc.abort = 1'b0;
    drain();

    // Asynchronous reset in the middle of a gap.
    go(8'b0000_0101, 4'd3, 4'd2, 4'd3, "reset_gap", "101g");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(obs), 32'h10);
    repeat (2) @(negedge clk);
    check("rst_hold", 32'(obs), 32'h10);
    rst_n = 1'b1;
    @(negedge clk);

    lb_on = 1'b1;
    go(8'b0000_0101, 4'd4, 4'd3, 4'd0, "loopback", "010101010101Dr");
    drain();
    lb_on = 1'b0;
    check("y_count", 32'(y_pos.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("y_pos[%0d]", i), 32'(y_pos[i]), 32'(y_exp[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-stream transmitter. It is the driving end for the Mealy sequence-detector family.
- Loads a programmable pattern and shifts it out MSB-first, one bit per Clk, repeated a programmable number of passes, with optional idle gaps between passes.
- Drives the detector's Din in system-level benches and in loopback self-test.

Parameters:
- PW, 8, maximum pattern width in bits.
- LW, 4, width of the Len field; must satisfy 2^LW > PW.
- RW, 4, width of the Repeat field (pass count).
- GW, 4, width of the Gap field (idle cycles between passes).
- IDLE_LVL, 1'b0, Dout level whenever Dvalid=0.

Ports:
- Clk, input, 1, system clock; all state changes on rising edge.
- Rst, input, 1, asynchronous active-low reset.
- Start, input, 1, request; accepted only when Ready=1.
- Abort, input, 1, synchronous cancel of the current transfer.
- Pattern, input, PW, bits to send; the field Pattern[Len-1:0] is used.
- Len, input, LW, number of bits per pass; 0 or values > PW are treated as PW.
- Repeat, input, RW, number of passes; 0 is treated as 1.
- Gap, input, GW, idle cycles inserted between passes; 0 means back-to-back.
- Ready, output, 1, high in IDLE; the generator can accept Start.
- Dout, output, 1, serial data, registered.
- Dvalid, output, 1, high while Dout carries a pattern bit.
- Busy, output, 1, high in SHIFT or GAP.
- Done, output, 1, one-cycle pulse after the last bit of the last pass.

Behaviour:
- Reset (Rst=0, asynchronous):
  - State=IDLE, Ready=1, Dout=IDLE_LVL, Dvalid=0, Busy=0, Done=0.
  - All counters and shadow registers cleared.
- All outputs are registered, with no combinational path from input to output.
- FSM states are IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Start=1 at edge k latches Pattern, effective Len, effective Repeat and Gap.
  - Shadow registers are then stable; later input changes have no effect.
  - Goes to SHIFT. Ready=0 from k+1.
- SHIFT:
  - First bit Pattern[Len-1] appears on Dout with Dvalid=1 in cycle k+1.
  - Subsequent bits follow MSB-first, one per cycle.
  - Bit counter counts Len-1 down to 0.
  - After the last bit of a pass, if passes remain and Gap>0, go to GAP.
  - If passes remain and Gap=0, restart at Pattern[Len-1] in the very next cycle, with no bubble.
  - If no passes remain, go to DONE.
- GAP:
  - Dout=IDLE_LVL, Dvalid=0, Busy=1 for exactly Gap cycles, then SHIFT.
- DONE:
  - Done=1, Dvalid=0, Busy=0, Ready=0 for one cycle, then IDLE.
- Timing:
  - With P passes, Done is high at cycle k + P*Len + (P-1)*Gap + 1.
  - Ready returns one cycle after Done.
- Start handling:
  - Start while Ready=0 is ignored (not queued).
  - Start in the DONE cycle is ignored.
- Abort:
  - Abort=1 in any non-IDLE state forces IDLE at the next edge, with Dvalid=0, Dout=IDLE_LVL, Ready=1.
  - Done is NOT pulsed.
  - Abort has priority over all internal transitions. Abort in IDLE has no effect.
  - Abort and Start both high in IDLE: Start is accepted.
- Reset mid-transfer:
  - Immediate return to reset values. Partial stream is dropped. No Done.
- Counter widths:
  - Bit counter is LW bits, pass counter RW bits, gap counter GW bits.
  - All decrementing; no wrap-around is reachable given the clamping rules above.

Decomposition:
- Package seq_gen_pkg:
  - State enum (IDLE, SHIFT, GAP, DONE) and the default width constants (PW, LW, RW, GW).
  - Helper function eff_len(Len) returning the clamped length.
- Sub-module bit_serializer:
  - Parallel-load, MSB-first shift register with a load strobe and a shift enable.
  - Reloaded from the shadow pattern at the start of every pass.
- FSM and counters live in seq_pattern_gen.

Test Plan:
- Single pass: after reset, Pattern=8'b0000_0101, Len=4, Repeat=1, Gap=0, Start pulse at edge k.
  - Dout=0,1,0,1 with Dvalid=1 in cycles k+1..k+4.
  - Done=1 at k+5; Ready=1 at k+6.
- Repeat with gap: Pattern=3'b101, Len=3, Repeat=2, Gap=2.
  - Stream 1,0,1 then two Dvalid=0 cycles at IDLE_LVL, then 1,0,1.
  - Done at k+9.
- Clamping: Len=0, Repeat=0, Pattern=8'hA5.
  - Eight bits 1,0,1,0,0,1,0,1, one pass, Done at k+9.
- Back-to-back passes and ignored Start: Gap=0, Repeat=3, Len=2, Pattern=2'b10.
  - Dout=1,0,1,0,1,0 continuous with Dvalid=1.
  - Start pulsed mid-transfer is ignored: exactly 6 valid bits.
- Abort and reset: Abort asserted during the 3rd bit of a Len=8 pass.
  - Next cycle: Dvalid=0, Ready=1, no Done.
  - Restart, then drop Rst mid-GAP: outputs go to reset values immediately, with no Clk edge required.
- Loopback: Pattern=4'b0101, Repeat=3, Gap=0 feeding the Mealy detector's Din.
  - Detector Y asserts at the expected bit positions.
